// File: rtl/lsu_mem_initiator_if.sv
// Request/response and data-memory signal bundle for lsu_mem_initiator.
// slave = the initiator itself; master = pipeline plus memory side.
interface lsu_mem_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  resp_valid_o;
  logic [DATA_WIDTH-1:0] resp_rdata_o;
  logic                  resp_err_o;
  logic                  mem_we_o;
  logic                  mem_byte_op_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wd_o;
  logic [DATA_WIDTH-1:0] mem_rd_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_we_o, mem_byte_op_o, mem_addr_o, mem_wd_o,
    output mem_rd_i
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RV32 load/store initiator: splits B/H/W accesses into word or byte beats on a word/byte memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halves/words return an error instead of being split.
module lsu_mem_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lsu_mem_initiator_if.slave bus
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int BEAT_W = $clog2(NBYTES);

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  mem_byte_op_q, mem_byte_op_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [BEAT_W-1:0]     last_q, last_d;
  logic [BEAT_W-1:0]     beat_nxt;
  logic                  misaligned;
  logic                  word_beat;
  logic                  trap;
  logic [DATA_WIDTH-1:0] rdata_ext;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size_i)
      SIZE_H:  misaligned = bus.req_addr_i[0];
      SIZE_W:  misaligned = |bus.req_addr_i[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign word_beat = (bus.req_size_i == SIZE_W) && !misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    err_d         = err_q;
    wdata_d       = wdata_q;
    asm_d         = asm_q;
    mem_addr_d    = mem_addr_q;
    mem_wd_d      = mem_wd_q;
    mem_byte_op_d = mem_byte_op_q;
    beat_d        = beat_q;
    last_d        = last_q;
    beat_nxt      = beat_q + BEAT_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          wdata_d = bus.req_wdata_i;
          beat_d  = '0;
          asm_d   = '0;
          if ((bus.req_size_i == SIZE_X) || trap) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d         = 1'b0;
            state_d       = ACCESS;
            mem_addr_d    = bus.req_addr_i;
            mem_byte_op_d = !word_beat;
            mem_wd_d      = word_beat ? bus.req_wdata_i
                          : {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, bus.req_wdata_i[BYTE_WIDTH-1:0]};
            case (bus.req_size_i)
              SIZE_B:  last_d = '0;
              SIZE_H:  last_d = BEAT_W'(1);
              default: last_d = word_beat ? '0 : BEAT_W'(NBYTES-1);
            endcase
          end
        end
      end

      ACCESS: begin
        if (!we_q) begin
          if (mem_byte_op_q) asm_d[int'(beat_q)*BYTE_WIDTH +: BYTE_WIDTH] = bus.mem_rd_i[BYTE_WIDTH-1:0];
          else               asm_d = bus.mem_rd_i;
        end
        if (beat_q == last_q) begin
          state_d = RESP;
        end else begin
          // Pre-load the next beat so the memory outputs come straight from flops.
          beat_d     = beat_nxt;
          mem_addr_d = mem_addr_q + DATA_WIDTH'(1);
          mem_wd_d   = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, wdata_q[int'(beat_nxt)*BYTE_WIDTH +: BYTE_WIDTH]};
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      SIZE_B:  rdata_ext = {{(DATA_WIDTH-BYTE_WIDTH){asm_q[BYTE_WIDTH-1] & ~uns_q}},
                            asm_q[BYTE_WIDTH-1:0]};
      SIZE_H:  rdata_ext = {{(DATA_WIDTH-2*BYTE_WIDTH){asm_q[2*BYTE_WIDTH-1] & ~uns_q}},
                            asm_q[2*BYTE_WIDTH-1:0]};
      default: rdata_ext = asm_q;
    endcase
  end

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.mem_we_o      = (state_q == ACCESS) && we_q;
  assign bus.mem_byte_op_o = mem_byte_op_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wd_o      = mem_wd_q;
  assign bus.resp_valid_o  = (state_q == RESP);
  assign bus.resp_err_o    = (state_q == RESP) && err_q;
  assign bus.resp_rdata_o  = ((state_q == RESP) && !we_q && !err_q) ? rdata_ext : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      err_q         <= 1'b0;
      wdata_q       <= '0;
      asm_q         <= '0;
      mem_addr_q    <= '0;
      mem_wd_q      <= '0;
      mem_byte_op_q <= 1'b0;
      beat_q        <= '0;
      last_q        <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      err_q         <= err_d;
      wdata_q       <= wdata_d;
      asm_q         <= asm_d;
      mem_addr_q    <= mem_addr_d;
      mem_wd_q      <= mem_wd_d;
      mem_byte_op_q <= mem_byte_op_d;
      beat_q        <= beat_d;
      last_q        <= last_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized scoreboard bench for lsu_mem_initiator with a byte-array reference model.
// Honours LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_lsu_mem_initiator;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wbeats;
    int          acc_cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   wcount = 0;
  int   mem_gen = 0;
  int   req_id = 0;

  exp_t       exp_q[$];
  logic [7:0] sim_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  lsu_mem_initiator_if #(.DATA_WIDTH(DW)) bus ();

  lsu_mem_initiator #(.DATA_WIDTH(DW), .BYTE_WIDTH(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sim_byte(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Memory behaviour: word port forced aligned, byte reads zero-extended, writes on falling edge.
  always @(bus.mem_addr_o or bus.mem_byte_op_o or mem_gen) begin
    logic [31:0] wa;
    wa = {bus.mem_addr_o[31:2], 2'b00};
    if (bus.mem_byte_op_o) bus.mem_rd_i = {24'h0, sim_byte(bus.mem_addr_o)};
    else bus.mem_rd_i = {sim_byte(wa + 32'd3), sim_byte(wa + 32'd2), sim_byte(wa + 32'd1), sim_byte(wa)};
  end

  always @(negedge clk) begin
    logic [31:0] wa;
    if (bus.mem_we_o) begin
      if (bus.mem_byte_op_o) sim_mem[bus.mem_addr_o] = bus.mem_wd_o[7:0];
      else begin
        for (int i = 0; i < 4; i++) begin
          wa = {bus.mem_addr_o[31:2], 2'b00} + 32'(i);
          sim_mem[wa] = bus.mem_wd_o[8*i +: 8];
        end
      end
      mem_gen++;
    end
  end

  task automatic check_output(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s (tag %0h): got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // Reference model: RV32 semantics straight on a byte array.
  task automatic model_issue(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    int          n;
    int          beats;
    bit          mis;
    logic [31:0] v;
    logic [31:0] a;
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 1; e.wbeats = 0; e.acc_cyc = 0; e.id = 0;
    if (size == 2'b11) begin
      e.err = 1'b1;
      return;
    end
    n   = 1 << size;
    mis = (int'(addr[1:0]) % n) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.err = 1'b1;
      return;
    end
`endif
    beats = (n == 4 && !mis) ? 1 : n;
    e.lat = beats + 1;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (we) ref_mem[a] = wdata[8*i +: 8];
      else v[8*i +: 8] = ref_byte(a);
    end
    if (we) e.wbeats = beats;
    else begin
      if (!uns && n == 1 && v[7])  v[31:8]  = '1;
      if (!uns && n == 2 && v[15]) v[31:16] = '1;
      e.rdata = v;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = bus.req_ready_o;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL ready_timeout: got req_ready_o=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
  endtask

  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    bit   ok;
    wait_ready(ok);
    if (!ok) return;
    drive_req(we, size, uns, addr, wdata);
    model_issue(we, size, uns, addr, wdata, e);
    e.acc_cyc = cyc;
    e.id      = req_id;
    req_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_output("drain_pending", req_id, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Store interrupted by reset after `keep` beats: no response, only those bytes land.
  task automatic reset_abort_test();
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    int          keep;
    bit          ok;
`ifdef LSU_MISALIGN_TRAP_EN
    a = 32'h0001_0010; sz = 2'b01; wd = 32'h0000_A55A; keep = 1;
`else
    a = 32'h0001_0003; sz = 2'b10; wd = 32'hCAFE_F00D; keep = 2;
`endif
    drain(50);
    wait_ready(ok);
    if (!ok) return;
    drive_req(1'b1, sz, 1'b0, a, wd);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    repeat (keep - 1) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("abort_ready", 32'hA, 32'(bus.req_ready_o), 32'd1);
    check_output("abort_resp_valid", 32'hA, 32'(bus.resp_valid_o), 32'd0);
    check_output("abort_mem_we", 32'hA, 32'(bus.mem_we_o), 32'd0);
    for (int i = 0; i < keep; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) wcount = 0;
    else begin
      if (bus.mem_we_o) wcount++;
      if (bus.resp_valid_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("[TB] FAIL unexpected_resp: got resp_valid_o=1, expected no response pending");
        end else begin
          e = exp_q.pop_front();
          check_output("resp_rdata", e.id, bus.resp_rdata_o, e.rdata);
          check_output("resp_err", e.id, 32'(bus.resp_err_o), 32'(e.err));
          check_output("resp_latency", e.id, 32'(cyc - e.acc_cyc), 32'(e.lat));
          check_output("write_beats", e.id, 32'(wcount), 32'(e.wbeats));
        end
        wcount = 0;
      end
    end
  end

  initial begin
    #400000;
    n_vec++;
    n_bad++;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 400000ns");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] ad;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_wdata_i    = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready", 0, 32'(bus.req_ready_o), 32'd1);
    check_output("rst_resp_valid", 0, 32'(bus.resp_valid_o), 32'd0);
    check_output("rst_resp_err", 0, 32'(bus.resp_err_o), 32'd0);
    check_output("rst_resp_rdata", 0, bus.resp_rdata_o, 32'h0);
    check_output("rst_mem_we", 0, 32'(bus.mem_we_o), 32'd0);
    check_output("rst_mem_byte_op", 0, 32'(bus.mem_byte_op_o), 32'd0);
    check_output("rst_mem_addr", 0, bus.mem_addr_o, 32'h0);
    check_output("rst_mem_wd", 0, bus.mem_wd_o, 32'h0);
    rst = 1'b0;

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h0001_0005, 32'h0000_0080);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h0001_0005, 32'h0);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h0001_0005, 32'h0);
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h0001_0011, 32'h0000_8123);
    apply_stimulus(1'b0, 2'b01, 1'b0, 32'h0001_0011, 32'h0);
    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h0001_0011, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0001_0003, 32'h1122_3344);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0001_0003, 32'h0);
    apply_stimulus(1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0);
    apply_stimulus(1'b1, 2'b11, 1'b0, 32'h0001_0020, 32'h5555_AAAA);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0);

    reset_abort_test();
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0001_0004, 32'h0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ad = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else ad = 32'h0001_0000 + 32'($urandom_range(0, 63));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      apply_stimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    end

    drain(50);
    foreach (ref_mem[a]) check_output("mem_byte", int'(a), 32'(sim_byte(a)), 32'(ref_mem[a]));
    foreach (sim_mem[a]) if (!ref_mem.exists(a)) check_output("mem_stray", int'(a), 32'(sim_mem[a]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
Load/store initiator between the pipeline's memory stage and the byte/word data memory. The data memory supports only two access types: a 32-bit word access that is forced 4-byte aligned, and a single-byte access whose reads are zero-extended.
- This block accepts full RV32 loads and stores (B/H/W, signed and unsigned) through a valid/ready handshake.
- It splits halfword and misaligned-word accesses into sequential byte beats.
- It assembles and sign-extends read data, then returns one response per request.

Parameters:
DATA_WIDTH, 32, data and address width
BYTE_WIDTH, 8, bits per memory byte lane

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
req_valid_i  input  1  request present
req_ready_o  output  1  block can accept a request
req_we_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  input  1  zero-extend load result (LBU/LHU); ignored for word and stores
req_addr_i  input  DATA_WIDTH  byte address
req_wdata_i  input  DATA_WIDTH  store data, little-endian, low bytes used for B/H
resp_valid_o  output  1  one-cycle pulse, request complete
resp_rdata_o  output  DATA_WIDTH  extended load data; 0 for stores and errors
resp_err_o  output  1  valid with resp_valid_o; illegal size (or trap, see feature)
mem_we_o  output  1  memory write enable
mem_byte_op_o  output  1  1 = byte beat, 0 = word beat
mem_addr_o  output  DATA_WIDTH  memory address
mem_wd_o  output  DATA_WIDTH  memory write data (byte beat: byte in [7:0])
mem_rd_i  input  DATA_WIDTH  memory read data, combinational from mem_addr_o

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset state: IDLE. req_ready_o=1; resp_valid_o=0; resp_err_o=0; resp_rdata_o=0; mem_we_o=0; mem_byte_op_o=0; mem_addr_o=0; mem_wd_o=0; beat counter=0; assembly register=0.
- IDLE:
  - req_ready_o=1.
  - Accept on req_valid_i & req_ready_o; latch all request fields.
  - Legal size: go to ACCESS. Illegal size: go to RESP with error.
- Beat plan, decided at acceptance:
  - Word with addr[1:0]==0: 1 word beat.
  - Byte: 1 byte beat.
  - Half: 2 byte beats at addr, addr+1.
  - Misaligned word: 4 byte beats at addr..addr+3.
  - Beat k targets addr+k, modulo 2^DATA_WIDTH (0xFFFFFFFF+1 wraps to 0).
- ACCESS:
  - Drive one beat per cycle: mem_addr_o, mem_byte_op_o, mem_wd_o, and mem_we_o=req_we.
  - Store beat k drives byte k of wdata on mem_wd_o[7:0].
  - Load: at each rising edge, capture mem_rd_i[7:0] (byte beat) into assembly byte k, or mem_rd_i (word beat).
  - After the last beat, go to RESP.
  - req_ready_o=0.
- RESP:
  - resp_valid_o=1 for exactly one cycle; mem_we_o=0; then return to IDLE.
  - Load result: byte/half sign-extended from bit 7/15 unless unsigned; word passed through.
- Latency: accept at cycle 0; beats in cycles 1..N; resp_valid_o in cycle N+1. Error response in cycle 1 with no memory beats.
- Back-to-back: the next request is accepted no earlier than the cycle after RESP.
- mem_we_o is asserted only in ACCESS for stores.
- mem_addr_o, mem_wd_o and mem_byte_op_o hold their last value outside ACCESS.
- Reset mid-ACCESS: abort immediately, no response. Store beats already written remain in memory.
- Memory writes on the falling edge, so a beat's write lands inside its own cycle. A load immediately following a store observes the stored data.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half with addr[0]!=0, or a word with addr[1:0]!=0, is not split. It goes directly to RESP with resp_err_o=1, resp_rdata_o=0 and no memory beat. Aligned halves still use 2 byte beats.
- Undefined: misaligned accesses are split into byte beats as described in Behaviour.

Test Plan:
- Store word 0xDEADBEEF at 0x10000, then load word at 0x10000 -> one word beat each; rdata 0xDEADBEEF; resp_valid_o in cycle 2 after acceptance.
- Store byte 0x80 at 0x10005, then LB and LBU at 0x10005 -> rdata 0xFFFFFF80, then 0x00000080.
- Store half 0x8123 at 0x10011, then LH and LHU -> 2 byte beats each at 0x10011 and 0x10012; rdata 0xFFFF8123, then 0x00008123; resp_valid_o in cycle 3.
- Store word 0x11223344 at 0x10003 -> 4 byte beats writing 44,33,22,11 to 0x10003..0x10006. Load word 0x10000 -> 0x44xxxxxx; load 0x10003 -> 0x11223344. With LSU_MISALIGN_TRAP_EN the store instead gives resp_err_o=1, zero beats, and memory unchanged.
- Request size 11 -> resp_err_o=1, rdata 0, mem_we_o never asserted, resp_valid_o in cycle 1.
- Assert rst_i during beat 2 of a 4-beat store -> next cycle: IDLE, req_ready_o=1, no resp_valid_o; beats 3-4 never written; a subsequent load of 0x10000 completes normally.
